// File: rtl/mode_ind_pkg.sv
// Shared types and limits for the front-panel mode indicator.
package mode_ind_pkg;
  typedef enum logic {STABLE, SETTLE} deb_state_t;
  typedef enum logic {STEADY, BLINK} blink_state_t;

  localparam int MAX_MODES = 16;

  // Counter width able to hold 0..limit-1, never narrower than one bit
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction
endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser plus debounce FSM; strobes commit once a candidate
// has been seen DEBOUNCE_CYCLES further times without change.
module sel_debounce
  import mode_ind_pkg::*;
#(
  parameter int SEL_W           = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  output logic             commit,
  output logic [SEL_W-1:0] cand
);
  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SEL_W-1:0] sync1, sel_s, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  deb_state_t       state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sel_s <= '0;
      cand  <= '0;
      cnt   <= '0;
      state <= STABLE;
    end else begin
      sync1 <= sel;
      sel_s <= sync1;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      STABLE: begin
        if (sel_s != cand) begin
          cand_nxt  = sel_s;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // Any bounce restarts the whole window on the new value
        if (sel_s != cand) begin
          cand_nxt = sel_s;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          commit    = 1'b1;
          state_nxt = STABLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = STABLE;
    endcase
  end
endmodule

// File: rtl/mode_indicator.sv
// Debounced mode select with one-hot LED indicator; define MODE_IND_BLINK_EN
// to blink the newly selected LED after each mode change.
module mode_indicator
  import mode_ind_pkg::*;
#(
  parameter int N_MODES           = 2,
  parameter int SEL_W             = $clog2(N_MODES),
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int BLINK_TOGGLES     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  output logic [SEL_W-1:0]   mode,
  output logic               mode_change,
  output logic               sel_err,
  output logic [N_MODES-1:0] led
);
  if (N_MODES < 2 || N_MODES > MAX_MODES || DEBOUNCE_CYCLES < 1 ||
      BLINK_HALF_CYCLES < 1 || BLINK_TOGGLES < 2 || (BLINK_TOGGLES % 2) != 0) begin : g_bad_param
    $error("mode_indicator: illegal parameter set");
  end

  localparam logic [SEL_W:0]     N_LIM = (SEL_W + 1)'(N_MODES);
  localparam logic [N_MODES-1:0] ONE   = N_MODES'(1);

  logic             commit, legal, chg;
  logic [SEL_W-1:0] cand, mode_nxt;

  sel_debounce #(
    .SEL_W          (SEL_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .commit(commit),
    .cand  (cand)
  );

  always_comb begin
    legal    = {1'b0, cand} < N_LIM;
    chg      = commit && legal && (cand != mode);
    mode_nxt = chg ? cand : mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= '0;
      mode_change <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      mode        <= mode_nxt;
      mode_change <= chg;
      if (commit) sel_err <= !legal;
    end
  end

`ifdef MODE_IND_BLINK_EN
  localparam int HALF_W = cnt_w(BLINK_HALF_CYCLES);
  localparam int TOG_W  = cnt_w(BLINK_TOGGLES);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF_CYCLES - 1);
  // Entry into BLINK is the first toggle, so the last counted one is T-2
  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(BLINK_TOGGLES - 2);

  blink_state_t      bstate, bstate_nxt;
  logic [HALF_W-1:0] half_cnt, half_nxt;
  logic [TOG_W-1:0]  tog_cnt, tog_nxt;
  logic              lit, lit_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate   <= STEADY;
      half_cnt <= '0;
      tog_cnt  <= '0;
      lit      <= 1'b1;
      led      <= ONE;
    end else begin
      bstate   <= bstate_nxt;
      half_cnt <= half_nxt;
      tog_cnt  <= tog_nxt;
      lit      <= lit_nxt;
      led      <= lit_nxt ? (ONE << mode_nxt) : '0;
    end
  end

  always_comb begin
    bstate_nxt = bstate;
    half_nxt   = half_cnt;
    tog_nxt    = tog_cnt;
    lit_nxt    = lit;
    if (chg) begin
      bstate_nxt = BLINK;
      half_nxt   = '0;
      tog_nxt    = '0;
      lit_nxt    = 1'b0;
    end else if (bstate == BLINK) begin
      if (half_cnt == HALF_LAST) begin
        half_nxt = '0;
        if (tog_cnt == TOG_LAST) begin
          bstate_nxt = STEADY;
          lit_nxt    = 1'b1;
        end else begin
          tog_nxt = tog_cnt + TOG_W'(1);
          lit_nxt = !lit;
        end
      end else begin
        half_nxt = half_cnt + HALF_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) led <= ONE;
    else     led <= ONE << mode_nxt;
  end
`endif
endmodule

// File: tb/tb_mode_indicator.sv
// Scoreboard bench: two instances (4 and 3 modes) share sel/rst and are
// compared against a run-length debounce model and an arithmetic blink model.
module tb_mode_indicator;
  localparam int D = 4, H = 3, T = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] sel = 2'd2;
  logic [1:0] mode_a, mode_b;
  logic       mc_a, mc_b, err_a, err_b;
  logic [3:0] led_a;
  logic [2:0] led_b;

  mode_indicator #(.N_MODES(4), .DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(H), .BLINK_TOGGLES(T)) u_a (
    .clk(clk), .rst(rst), .sel(sel), .mode(mode_a), .mode_change(mc_a), .sel_err(err_a), .led(led_a));
  mode_indicator #(.N_MODES(3), .DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(H), .BLINK_TOGGLES(T)) u_b (
    .clk(clk), .rst(rst), .sel(sel), .mode(mode_b), .mode_change(mc_b), .sel_err(err_b), .led(led_b));

  always #5 clk = ~clk;

  typedef struct { int cyc; int mode; } ev_t;
  ev_t evq0[$], evq1[$];

  int  nm[2] = '{4, 3};
  int  s1[2], s2[2], cand[2], run[2], pend[2], m_mode[2], m_err[2], c0[2];
  int  cyc = 0, ntests = 0, nfail = 0;
  bit  started = 0;

  // Reference: sel passes a two-sample delay, then a value commits once it
  // has been seen D+1 times in a row since it became the candidate.
  task automatic model_step(input int d);
    int ss;
    ev_t ev;
    if (rst) begin
      s1[d] = 0; s2[d] = 0; cand[d] = 0; run[d] = 0; pend[d] = 0;
      m_mode[d] = 0; m_err[d] = 0; c0[d] = -1000;
      return;
    end
    ss = s2[d]; s2[d] = s1[d]; s1[d] = int'(sel);
    if (ss != cand[d]) begin
      cand[d] = ss; pend[d] = 1; run[d] = 1;
    end else if (pend[d] != 0) begin
      run[d]++;
      if (run[d] == D + 1) begin
        pend[d] = 0;
        if (cand[d] < nm[d]) begin
          m_err[d] = 0;
          if (cand[d] != m_mode[d]) begin
            m_mode[d] = cand[d];
            c0[d] = cyc;
            ev.cyc = cyc; ev.mode = cand[d];
            if (d == 0) evq0.push_back(ev); else evq1.push_back(ev);
          end
        end else m_err[d] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
    started = 1;
  end

  function automatic logic [3:0] exp_led(input int d);
    int  k;
    bit  lit;
    k = cyc - c0[d];
`ifdef MODE_IND_BLINK_EN
    lit = (k >= H * (T - 1)) ? 1'b1 : (((k / H) % 2) == 1);
`else
    lit = 1'b1;
`endif
    return lit ? (4'd1 << m_mode[d]) : 4'd0;
  endfunction

  task automatic check(input int d, input logic [1:0] m, input logic mc, input logic e, input logic [3:0] l);
    ev_t ev;
    int  qn;
    logic [1:0] em;
    logic [3:0] el;
    em = 2'(m_mode[d]);
    el = exp_led(d);
    ntests++;
    if (m !== em) begin
      nfail++; $display("FAIL mode dut%0d cyc %0d: got %0h expected %0h", d, cyc, m, em);
    end
    ntests++;
    if (e !== 1'(m_err[d])) begin
      nfail++; $display("FAIL sel_err dut%0d cyc %0d: got %0b expected %0b", d, cyc, e, m_err[d]);
    end
    ntests++;
    if (l !== el) begin
      nfail++; $display("FAIL led dut%0d cyc %0d: got %b expected %b", d, cyc, l, el);
    end
    qn = (d == 0) ? evq0.size() : evq1.size();
    if (mc === 1'b1) begin
      ntests++;
      if (qn == 0) begin
        nfail++; $display("FAIL mode_change dut%0d cyc %0d: got pulse expected none", d, cyc);
      end else begin
        ev = (d == 0) ? evq0.pop_front() : evq1.pop_front();
        if (ev.cyc != cyc || ev.mode != int'(m)) begin
          nfail++;
          $display("FAIL mode_change dut%0d: got cyc %0d mode %0d expected cyc %0d mode %0d", d, cyc, m, ev.cyc, ev.mode);
        end
      end
    end else if (qn != 0) begin
      ev = (d == 0) ? evq0[0] : evq1[0];
      if (ev.cyc <= cyc) begin
        ntests++; nfail++;
        $display("FAIL mode_change dut%0d cyc %0d: got no pulse expected pulse mode %0d", d, cyc, ev.mode);
        if (d == 0) void'(evq0.pop_front()); else void'(evq1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check(0, mode_a, mc_a, err_a, led_a);
      check(1, mode_b, mc_b, err_b, {1'b0, led_b});
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    @(negedge clk); sel = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(2, 12);                                   // commit of value held through reset
    hold(0, 14);
    hold(3, 22);                                   // full blink pattern
    hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2); hold(1, 20);  // bounce
    hold(3, 8);  hold(1, 22);                      // change during blink
    hold(3, 14); hold(1, 22);                      // illegal on 3-mode instance
    hold(2, 9);  pulse_rst(); hold(2, 20);         // reset mid-blink
    hold(0, 4);  pulse_rst(); hold(0, 16);         // reset mid-settle
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_rst();
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end
    hold(sel, 30);
    ntests++;
    if (evq0.size() != 0) begin
      nfail++; $display("FAIL pending_events dut0: got %0d left expected 0", evq0.size());
    end
    ntests++;
    if (evq1.size() != 0) begin
      nfail++; $display("FAIL pending_events dut1: got %0d left expected 0", evq1.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mode_indicator.md
# mode_indicator

Parametrised mode-select and indicator block for the Morse front panel. It synchronises and debounces a binary-encoded mode switch bank and commits a stable mode number. It drives one-hot mode LEDs, blinking the newly selected LED briefly after each change. It replaces the fixed two-mode, undebounced switch-to-LED indicator and gives the encoder/decoder datapath a clean `mode` value plus a one-cycle `mode_change` strobe.

## Interface
- `N_MODES`, 2, number of modes/LEDs; legal range 2..16
- `SEL_W`, `$clog2(N_MODES)`, width of `sel`/`mode`; derived, never overridden
- `DEBOUNCE_CYCLES`, 1000000, number of consecutive stable samples required to commit; minimum 1
- `BLINK_HALF_CYCLES`, 12500000, LED on/off half-period during change blink; minimum 1
- `BLINK_TOGGLES`, 6, number of LED toggles after a change; even, minimum 2
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `sel`  in  SEL_W  raw switch bank, asynchronous to `clk`
- `mode`  out  SEL_W  committed mode number
- `mode_change`  out  1  one-cycle strobe, high in the cycle `mode` takes a new value
- `sel_err`  out  1  high while the debounced candidate is >= N_MODES
- `led`  out  N_MODES  one-hot indicator; only bit `mode` is ever set

## Operation
- Reset values: `mode`=0, `led`=1 (bit 0), `mode_change`=0, `sel_err`=0, sync flops=0, candidate=0, counters=0, blink FSM=STEADY.
- Two-flop synchroniser on `sel` produces `sel_s`.
- Debounce FSM, states STABLE and SETTLE:
  - STABLE: `sel_s` != candidate → load candidate with `sel_s`, clear count, go to SETTLE.
  - SETTLE: `sel_s` != candidate → reload candidate, clear count, stay in SETTLE.
  - SETTLE: otherwise increment count. When count==DEBOUNCE_CYCLES-1, go to STABLE and commit.
- Commit:
  - candidate < N_MODES and != `mode`: update `mode` and pulse `mode_change`.
  - candidate == `mode`: no pulse, no blink.
  - candidate >= N_MODES: `mode` held, `sel_err`=1 until a legal candidate commits.
- Blink FSM, states STEADY and BLINK:
  - Any `mode_change` enters BLINK: `led[mode]` starts off and toggles every BLINK_HALF_CYCLES, BLINK_TOGGLES times, then returns to STEADY with the LED on.
  - A new `mode_change` during BLINK restarts the sequence on the new LED. The old LED goes off in the same cycle.
- Counters saturate-free: widths are `$clog2` of their limits. No wrap-around is reachable.

## Timing
- `sel` is stable before edge E0 (first sampling edge).
  - `sel_s` is valid after E1.
  - Candidate is loaded at E2.
  - `mode` and `mode_change` update at edge E2+DEBOUNCE_CYCLES.
  - `mode_change` falls at the next edge.
- Bounce during SETTLE restarts the full DEBOUNCE_CYCLES window.
- `led` is registered and updates on the same edge as `mode`. In BLINK, the first half-period is off.
- `rst` asserted mid-SETTLE or mid-BLINK returns all outputs to reset values at that edge. The block re-debounces `sel` from scratch after release.
- `sel_err` changes on the commit edge only.

## Configuration
- `MODE_IND_BLINK_EN` defined: blink FSM and BLINK_* parameters are active, as above.
- Undefined: blink logic is not compiled. `led` = one-hot of `mode` at all times, and BLINK_* parameters are ignored. Debounce timing and all other outputs are unchanged.

## Structure
- Package `mode_ind_pkg` holds:
  - `deb_state_t` {STABLE, SETTLE}
  - `blink_state_t` {STEADY, BLINK}
  - constant `MAX_MODES`=16, used for the parameter check
- Sub-module `sel_debounce` contains the synchroniser, candidate register, counter and debounce FSM. Its outputs are a commit strobe plus the candidate. `mode_indicator` adds the range check, mode register and blink FSM.

## Test plan
Bench parameters: N_MODES=4, DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=3, BLINK_TOGGLES=4, with `MODE_IND_BLINK_EN` defined.
- Reset with `sel`=2, then release → `mode`=0 and `led`=0001 during reset. After release: `mode`=2, `mode_change` high one cycle, at release edge+6.
- `sel` 0→3, stable → `mode`=3 exactly 6 edges after the change is sampled. `led[3]` pattern is off3,on3,off3,on3, then steady on.
- `sel` toggles 0→1→0 at 2-cycle spacing, then settles at 1 → each toggle restarts the window. Exactly one `mode_change`, 6 edges after the last toggle.
- `sel`=3 commit, then `sel`=1 during blink → `led[3]` clears on the commit edge and `led[1]` blink restarts from off.
- N_MODES=3, `sel`=3 → `mode` held, `sel_err`=1, no `mode_change`. Then `sel`=1 → `sel_err`=0 and `mode`=1.
- `MODE_IND_BLINK_EN` undefined, `sel`=1 → `led`=0010 on the commit edge and stays constant.
